// File: rtl/cmos_pkg.sv
// Shared types and constants for the OV5640 DVP capture path.
package cmos_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned PIX_W   = 16;

  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic [1:0] {
    ST_WAIT_CFG = 2'd0,
    ST_SKIP     = 2'd1,
    ST_WAIT_VS  = 2'd2,
    ST_ACTIVE   = 2'd3
  } cap_state_t;

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == COORD_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dvp_byte_packer.sv
// Registers the DVP pins once, pairs bytes into RGB565 words and flags
// lines that end on an unpaired byte.
module dvp_byte_packer
  import cmos_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vsync,
  input  logic             i_href,
  input  logic [7:0]       i_db,
  output logic             o_vs,
  output logic             o_href,
  output logic             o_href_fall,
  output logic             o_pix_valid,
  output logic [PIX_W-1:0] o_pix_data,
  output logic             o_odd_drop
);

  logic       r_vs;
  logic       r_href;
  logic       r_href_d;
  logic [7:0] r_db;
  logic [7:0] r_hi;
  logic       r_tog;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs     <= 1'b0;
      r_href   <= 1'b0;
      r_href_d <= 1'b0;
      r_db     <= '0;
      r_hi     <= '0;
      r_tog    <= 1'b0;
    end else begin
      r_vs     <= i_vsync;
      r_href   <= i_href;
      r_db     <= i_db;
      r_href_d <= r_href;
      if (!r_href) begin
        r_tog <= 1'b0;
      end else begin
        r_tog <= ~r_tog;
        if (!r_tog) r_hi <= r_db;
      end
    end
  end

  // r_tog still holds the line's byte parity on the first cycle after href falls
  assign o_vs        = r_vs;
  assign o_href      = r_href;
  assign o_href_fall = r_href_d & ~r_href;
  assign o_pix_valid = r_href & r_tog;
  assign o_pix_data  = {r_hi, r_db};
  assign o_odd_drop  = o_href_fall & r_tog;

endmodule

// File: rtl/cmos_rgb565_capture.sv
// OV5640 DVP capture: config gating, frame skip, RGB565 pixel stream with
// coordinates and markers, and per-frame geometry checking.
module cmos_rgb565_capture
  import cmos_pkg::*;
#(
  parameter int unsigned H_RES       = 1280,
  parameter int unsigned V_RES       = 720,
  parameter int unsigned SKIP_FRAMES = 10,
  parameter bit          VS_ACTIVE   = 1'b1
) (
  input  logic               cmos_pclk,
  input  logic               I_rst_n,
  input  logic               I_cfg_done,
  input  logic               cmos_vsync,
  input  logic               cmos_href,
  input  logic [7:0]         cmos_db,
  output logic               O_pix_valid,
  output logic [PIX_W-1:0]   O_pix_data,
  output logic               O_sof,
  output logic               O_eol,
  output logic [COORD_W-1:0] O_x,
  output logic [COORD_W-1:0] O_y,
  output logic               O_frame_done,
  output logic               O_frame_err,
  output logic [15:0]        O_frame_cnt
);

  localparam logic [COORD_W-1:0] LP_H_RES  = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] LP_H_LAST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] LP_V_RES  = COORD_W'(V_RES);
  localparam logic [7:0]         LP_SKIP   = 8'(SKIP_FRAMES);

  logic               w_vs;
  logic               w_href;
  logic               w_href_fall;
  logic               w_pix_valid;
  logic [PIX_W-1:0]   w_pix_data;
  logic               w_odd_drop;
  logic               w_vs_act;
  logic               w_vs_rise;
  logic               w_line_has_px;
  logic [COORD_W-1:0] w_y_closed;

  logic               r_cfg_meta;
  logic               r_cfg_sync;
  logic               r_vs_act_d;
  logic [7:0]         r_skip_cnt;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  cap_state_t         r_state;
  cap_state_t         w_state_nxt;

  dvp_byte_packer u_packer (
    .i_clk       (cmos_pclk),
    .i_rst_n     (I_rst_n),
    .i_vsync     (cmos_vsync),
    .i_href      (cmos_href),
    .i_db        (cmos_db),
    .o_vs        (w_vs),
    .o_href      (w_href),
    .o_href_fall (w_href_fall),
    .o_pix_valid (w_pix_valid),
    .o_pix_data  (w_pix_data),
    .o_odd_drop  (w_odd_drop)
  );

  assign w_vs_act      = (w_vs == VS_ACTIVE);
  assign w_vs_rise     = w_vs_act & ~r_vs_act_d;
  assign w_line_has_px = (r_x != '0);
  // A line closing on the same cycle as vsync counts toward this frame
  assign w_y_closed    = (w_href_fall && w_line_has_px) ? sat_inc(r_y) : r_y;

  always_comb begin
    w_state_nxt = r_state;
    if (!r_cfg_sync) begin
      w_state_nxt = ST_WAIT_CFG;
    end else begin
      case (r_state)
        ST_WAIT_CFG: w_state_nxt = ST_SKIP;
        ST_SKIP:     if (r_skip_cnt == LP_SKIP) w_state_nxt = ST_WAIT_VS;
        ST_WAIT_VS:  if (w_vs_rise) w_state_nxt = ST_ACTIVE;
        ST_ACTIVE:   w_state_nxt = ST_ACTIVE;
        default:     w_state_nxt = ST_WAIT_CFG;
      endcase
    end
  end

  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_cfg_meta   <= 1'b0;
      r_cfg_sync   <= 1'b0;
      r_vs_act_d   <= 1'b1;  // no spurious vsync edge straight out of reset
      r_skip_cnt   <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_state      <= ST_WAIT_CFG;
      O_pix_valid  <= 1'b0;
      O_pix_data   <= '0;
      O_sof        <= 1'b0;
      O_eol        <= 1'b0;
      O_x          <= '0;
      O_y          <= '0;
      O_frame_done <= 1'b0;
      O_frame_err  <= 1'b0;
      O_frame_cnt  <= '0;
    end else begin
      r_cfg_meta   <= I_cfg_done;
      r_cfg_sync   <= r_cfg_meta;
      r_vs_act_d   <= w_vs_act;
      r_state      <= w_state_nxt;
      O_pix_valid  <= 1'b0;
      O_sof        <= 1'b0;
      O_eol        <= 1'b0;
      O_frame_done <= 1'b0;

      if (!r_cfg_sync || r_state == ST_WAIT_CFG) begin
        r_skip_cnt <= '0;
        r_x        <= '0;
        r_y        <= '0;
      end else begin
        if (r_state == ST_SKIP && w_vs_rise && r_skip_cnt != LP_SKIP)
          r_skip_cnt <= r_skip_cnt + 1'b1;

        if (r_state == ST_ACTIVE) begin
          if (w_pix_valid) begin
            O_pix_valid <= 1'b1;
            O_pix_data  <= w_pix_data;
            O_x         <= r_x;
            O_y         <= r_y;
            O_sof       <= (r_x == '0) && (r_y == '0);
            O_eol       <= (r_x == LP_H_LAST);
            r_x         <= sat_inc(r_x);
          end

          if (w_href_fall) begin
            r_x <= '0;
            if (w_line_has_px) begin
              r_y <= sat_inc(r_y);
              if (r_x != LP_H_RES) O_frame_err <= 1'b1;
            end
            if (w_odd_drop) O_frame_err <= 1'b1;
          end

          if (w_href && w_vs_act) O_frame_err <= 1'b1;

          if (w_vs_rise) begin
            r_y          <= '0;
            O_frame_done <= 1'b1;
            O_frame_cnt  <= O_frame_cnt + 1'b1;
            if (w_y_closed != LP_V_RES) O_frame_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cmos_rgb565_capture.sv
// Directed bench for cmos_rgb565_capture with a pixel / frame-done scoreboard.
module tb_cmos_rgb565_capture;

  localparam int H_RES = 4;
  localparam int V_RES = 2;
  localparam int SKIP  = 2;

  typedef struct {
    logic [15:0] d;
    logic [11:0] x;
    logic [11:0] y;
    logic        sof;
    logic        eol;
    int unsigned cyc;
  } pix_t;

  logic        clk;
  logic        I_rst_n;
  logic        I_cfg_done;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_db;
  logic        O_pix_valid;
  logic [15:0] O_pix_data;
  logic        O_sof;
  logic        O_eol;
  logic [11:0] O_x;
  logic [11:0] O_y;
  logic        O_frame_done;
  logic        O_frame_err;
  logic [15:0] O_frame_cnt;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  logic [7:0]  bval  = 8'h12;
  pix_t        exp_q[$];
  int unsigned fd_q[$];
  pix_t        e;
  int unsigned efd;
  logic        prev_pv = 1'b0;
  logic        prev_fd = 1'b0;

  cmos_rgb565_capture #(
    .H_RES       (H_RES),
    .V_RES       (V_RES),
    .SKIP_FRAMES (SKIP),
    .VS_ACTIVE   (1'b1)
  ) dut (
    .cmos_pclk    (clk),
    .I_rst_n      (I_rst_n),
    .I_cfg_done   (I_cfg_done),
    .cmos_vsync   (cmos_vsync),
    .cmos_href    (cmos_href),
    .cmos_db      (cmos_db),
    .O_pix_valid  (O_pix_valid),
    .O_pix_data   (O_pix_data),
    .O_sof        (O_sof),
    .O_eol        (O_eol),
    .O_x          (O_x),
    .O_y          (O_y),
    .O_frame_done (O_frame_done),
    .O_frame_err  (O_frame_err),
    .O_frame_cnt  (O_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops expected pixels / frame-done pulses as they appear
  always @(negedge clk) begin
    if (O_pix_valid) begin
      total++;
      assert (!prev_pv) else begin
        bad++; $error("FAIL pix_b2b got=back-to-back exp=gap cyc=%0d", cyc);
      end
      total++;
      assert (exp_q.size() > 0) else begin
        bad++; $error("FAIL pix_unexpected got=%h exp=none cyc=%0d", O_pix_data, cyc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        assert (O_pix_data === e.d && O_x === e.x && O_y === e.y &&
                O_sof === e.sof && O_eol === e.eol && cyc == e.cyc) else begin
          bad++;
          $error("FAIL pix got d=%h x=%0d y=%0d sof=%b eol=%b cyc=%0d exp d=%h x=%0d y=%0d sof=%b eol=%b cyc=%0d",
                 O_pix_data, O_x, O_y, O_sof, O_eol, cyc, e.d, e.x, e.y, e.sof, e.eol, e.cyc);
        end
      end
    end
    prev_pv = O_pix_valid;

    if (O_frame_done) begin
      total++;
      assert (!prev_fd) else begin
        bad++; $error("FAIL fd_width got=multi-cycle exp=one cycle cyc=%0d", cyc);
      end
      total++;
      assert (fd_q.size() > 0) else begin
        bad++; $error("FAIL fd_unexpected got=pulse exp=none cyc=%0d", cyc);
      end
      if (fd_q.size() > 0) begin
        efd = fd_q.pop_front();
        total++;
        assert (cyc == efd) else begin
          bad++; $error("FAIL fd_time got=%0d exp=%0d", cyc, efd);
        end
      end
    end
    prev_fd = O_frame_done;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++; $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, {27'd0, O_pix_valid, O_sof, O_eol, O_frame_done, O_frame_err}, 32'd0);
    chk({tag, "_data"}, {16'd0, O_pix_data}, 32'd0);
    chk({tag, "_xy"}, {8'd0, O_x, O_y}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, O_frame_cnt}, 32'd0);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(input logic [7:0] b, input logic h, input logic v);
    @(posedge clk);
    #2;
    cmos_db    = b;
    cmos_href  = h;
    cmos_vsync = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(8'h00, 1'b0, 1'b0);
  endtask

  task automatic vsync_pulse(input bit exp_fd);
    drv(8'h00, 1'b0, 1'b1);
    if (exp_fd) fd_q.push_back(cyc + 2);
    drv(8'h00, 1'b0, 1'b1);
    drv(8'h00, 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic send_line(input int nb, input bit cap, input int y, input int gap);
    logic [7:0] hi;
    pix_t       p;
    hi = 8'h00;
    for (int i = 0; i < nb; i++) begin
      drv(bval, 1'b1, 1'b0);
      if (i % 2 == 0) begin
        hi = bval;
      end else if (cap) begin
        p.d   = {hi, bval};
        p.x   = 12'(i / 2);
        p.y   = 12'(y);
        p.sof = (i / 2 == 0) && (y == 0);
        p.eol = (i / 2 == H_RES - 1);
        p.cyc = cyc + 2;
        exp_q.push_back(p);
      end
      bval = bval + 8'h22;
    end
    idle(gap);
  endtask

  task automatic send_frame(input int nl, input int nb, input bit cap);
    for (int l = 0; l < nl; l++) send_line(nb, cap, l, 2);
  endtask

  task automatic skip_frames();
    for (int f = 0; f < SKIP; f++) begin
      vsync_pulse(1'b0);
      send_frame(2, 8, 1'b0);
    end
    vsync_pulse(1'b0);
  endtask

  initial begin
    I_rst_n    = 1'b0;
    I_cfg_done = 1'b0;
    cmos_vsync = 1'b0;
    cmos_href  = 1'b0;
    cmos_db    = 8'h00;
    repeat (3) @(posedge clk);
    settle();
    chk_zero("reset");
    @(posedge clk);
    #2;
    I_rst_n = 1'b1;

    // no capture while configuration is incomplete
    for (int f = 0; f < 3; f++) begin
      vsync_pulse(1'b0);
      send_frame(2, 8, 1'b0);
    end
    vsync_pulse(1'b0);
    settle();
    chk("nocfg_cnt", {16'd0, O_frame_cnt}, 32'd0);
    chk("nocfg_err", {31'd0, O_frame_err}, 32'd0);

    // skip two frames, capture the third
    I_cfg_done = 1'b1;
    idle(6);
    skip_frames();
    bval = 8'h12;
    send_frame(2, 8, 1'b1);
    vsync_pulse(1'b1);
    settle();
    chk("good_cnt", {16'd0, O_frame_cnt}, 32'd1);
    chk("good_err", {31'd0, O_frame_err}, 32'd0);
    chk("good_qempty", exp_q.size(), 32'd0);

    // three lines against V_RES=2
    send_frame(3, 8, 1'b1);
    idle(2);
    settle();
    chk("vres_err_pre", {31'd0, O_frame_err}, 32'd0);
    vsync_pulse(1'b1);
    settle();
    chk("vres_cnt", {16'd0, O_frame_cnt}, 32'd2);
    chk("vres_err", {31'd0, O_frame_err}, 32'd1);

    // async reset in the middle of a line
    send_line(5, 1'b1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("prerst_valid", {31'd0, O_pix_valid}, 32'd1);
    chk("prerst_x", {20'd0, O_x}, 32'd1);
    I_rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    cmos_href = 1'b0;
    cmos_db   = 8'h00;
    idle(2);
    I_rst_n = 1'b1;
    idle(6);
    skip_frames();
    bval = 8'h12;
    send_frame(2, 8, 1'b1);
    vsync_pulse(1'b1);
    settle();
    chk("postrst_cnt", {16'd0, O_frame_cnt}, 32'd1);
    chk("postrst_err", {31'd0, O_frame_err}, 32'd0);

    // nine-byte line: four pixels, trailing byte dropped
    send_line(9, 1'b1, 0, 4);
    settle();
    chk("odd_err", {31'd0, O_frame_err}, 32'd1);
    send_line(8, 1'b1, 1, 2);
    vsync_pulse(1'b1);
    settle();
    chk("odd_cnt", {16'd0, O_frame_cnt}, 32'd2);

    // cfg_done dropped mid-line, then full skip again on re-raise
    send_line(8, 1'b1, 0, 2);
    send_line(4, 1'b1, 1, 0);
    I_cfg_done = 1'b0;
    send_line(4, 1'b0, 1, 2);
    send_line(8, 1'b0, 2, 2);
    vsync_pulse(1'b0);
    send_frame(2, 8, 1'b0);
    settle();
    chk("cfgdrop_qempty", exp_q.size(), 32'd0);
    I_cfg_done = 1'b1;
    idle(6);
    skip_frames();
    bval = 8'h12;
    send_frame(2, 8, 1'b1);
    vsync_pulse(1'b1);
    settle();
    chk("recfg_qempty", exp_q.size(), 32'd0);
    chk("recfg_fdempty", fd_q.size(), 32'd0);

    // short line, then an over-long line that keeps counting x
    I_rst_n = 1'b0;
    idle(2);
    I_rst_n = 1'b1;
    idle(6);
    settle();
    chk("rst2_err", {31'd0, O_frame_err}, 32'd0);
    skip_frames();
    bval = 8'h12;
    send_line(6, 1'b1, 0, 4);
    settle();
    chk("short_err", {31'd0, O_frame_err}, 32'd1);
    send_line(10, 1'b1, 1, 2);
    vsync_pulse(1'b1);
    settle();
    chk("long_cnt", {16'd0, O_frame_cnt}, 32'd1);
    chk("final_qempty", exp_q.size(), 32'd0);
    chk("final_fdempty", fd_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmos_rgb565_capture.md
# cmos_rgb565_capture

Capture stage directly downstream of the OV5640 DVP pins, clocked by the camera pixel clock. It gates capture until sensor configuration is complete and discards a settling number of frames. It then packs byte pairs into RGB565 pixels with frame/line markers and pixel coordinates, and checks every frame's geometry. Its output feeds the frame-buffer write path.

## Interface
- H_RES, 1280: expected pixels per line.
- V_RES, 720: expected lines per frame.
- SKIP_FRAMES, 10: complete frames discarded after cfg_done before capture starts; range 0..255.
- VS_ACTIVE, 1: level of cmos_vsync during vertical blanking pulse (1 = active-high).
- cmos_pclk  in  1  pixel/byte clock; all logic on rising edge. Reset I_rst_n, asynchronous, active-low; clock cmos_pclk.
- I_rst_n  in  1  async active-low reset.
- I_cfg_done  in  1  SCCB register load complete; level, synchronised here (2 FFs).
- cmos_vsync  in  1  camera vertical sync.
- cmos_href  in  1  camera line-valid.
- cmos_db  in  8  camera byte data.
- O_pix_valid  out  1  one-cycle strobe, O_pix_data valid.
- O_pix_data  out  16  RGB565, first byte of pair in [15:8].
- O_sof  out  1  high with first pixel of frame (x=0,y=0).
- O_eol  out  1  high with last pixel of each line.
- O_x  out  12  column of current pixel.
- O_y  out  12  row of current pixel.
- O_frame_done  out  1  one-cycle pulse at vsync assertion ending a captured frame.
- O_frame_err  out  1  sticky error flag; cleared only by reset.
- O_frame_cnt  out  16  captured frames completed, wraps at 65535->0.

## Operation
- All DVP inputs registered once (r_vs, r_href, r_db) before use; edge detect on r_vs/r_href.
- FSM states:
  - WAIT_CFG: idle until synced cfg_done=1; then SKIP, skip counter = 0.
  - SKIP: count vsync assertions. When count reaches SKIP_FRAMES, go to WAIT_VS. SKIP_FRAMES=0 goes straight to WAIT_VS.
  - WAIT_VS: wait for vsync assertion edge; then ACTIVE.
  - ACTIVE: capture. Each later vsync assertion ends the frame and starts the next one; state stays ACTIVE.
- cfg_done deasserting in any state → WAIT_CFG on next cycle, counters cleared, no output strobes.
- Byte pairing:
  - Byte toggle cleared when r_href=0.
  - While r_href=1, even byte latched to high half; odd byte completes the pixel.
- Counters:
  - x increments per pixel and clears at href fall.
  - y increments at href fall if ≥1 pixel was emitted on the line; it clears at vsync assertion.
  - Line counter and pixel counter saturate at 4095.
- Error (O_frame_err set) on any of:
  - line with pixel count ≠ H_RES;
  - href falling with odd byte count (partial pixel dropped);
  - frame ended with line count ≠ V_RES;
  - r_href=1 while r_vs is active.
- Errored frame still counted in O_frame_cnt and still pulses O_frame_done.
- O_eol asserted when x = H_RES-1. Lines longer than H_RES continue emitting pixels with x counting on, and are flagged.

## Timing
- Reset values: all outputs 0; FSM = WAIT_CFG; counters 0; toggle 0.
- Latency: odd byte on cmos_db at edge n → O_pix_valid=1 during cycle after edge n+1; O_x/O_y/O_sof/O_eol aligned to same cycle.
- O_pix_valid maximum rate 1 per 2 pclk; never back-to-back.
- O_frame_done: one cycle, two edges after vsync assertion on pins; only in ACTIVE, and only if the frame had a start (not the first vsync after WAIT_VS).
- Simultaneous href fall and vsync assertion: line closed first (y update, checks), then frame checks use updated y.
- Async reset mid-line: outputs drop immediately; after release, FSM restarts in WAIT_CFG including the full frame skip.

## Structure
- Shared package cmos_pkg:
  - FSM state encoding (WAIT_CFG, SKIP, WAIT_VS, ACTIVE);
  - 12-bit coordinate width constant;
  - RGB565 pixel width constant.
- One sub-module, dvp_byte_packer: input register, href edge detect, byte toggle, 16-bit assembly, odd-byte flag.
- Parent holds FSM, counters, checks.

## Test plan
- Reset with cfg_done=0, drive 3 frames → no O_pix_valid, O_frame_cnt=0.
- SKIP_FRAMES=2, H_RES=4, V_RES=2, bytes 0x12,0x34,... → first frame output starts on the third post-cfg frame.
  - First pixel 0x1234 with O_sof=1, x=0, y=0.
  - O_eol at x=3.
  - O_frame_done after frame; O_frame_cnt=1; O_frame_err=0.
- Line of 9 bytes (H_RES=4) → 4 pixels emitted, 9th byte dropped, O_frame_err=1.
- Frame of 3 lines with V_RES=2 → O_frame_err=1 at the vsync ending the frame; O_frame_cnt still increments.
- cfg_done dropped mid-frame → strobes stop within 3 cycles. Re-raise → full skip repeats before capture.
- Assert I_rst_n low mid-line → all outputs 0 asynchronously; the next frame after the skip captures correctly, err=0.
